// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Builds RV32I instruction words from separate field inputs, with
//            optional immediate range checking. There is one output register
//            stage, so a word appears one cycle after its request is taken.
//            A ready/valid handshake runs on both sides.
//            Illegal opcodes, and out-of-range immediates when IMM_CHECK=1,
//            produce a NOP with out_err set. Counters track accepted requests
//            and error words.
// Ports    : clk, rst_n            - clock, async active-low reset
//            in_valid / in_ready   - request handshake
//            in_opcode..in_funct7  - RV32I fields; in_imm signed, unshifted
//            out_valid / out_ready - result handshake
//            out_instr / out_err   - encoded word and error flag
//            clr_cnt               - synchronous clear of both counters
//            enc_count / err_count - accepted-request count / error count
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int IMM_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    input  logic        clr_cnt,
    output logic [15:0] enc_count,
    output logic [7:0]  err_count
);

    localparam logic [31:0] c_nop      = 32'h0000_0013;
    localparam bit          c_check    = (IMM_CHECK != 0);

    localparam logic [6:0]  c_op_imm   = 7'b0010011;
    localparam logic [6:0]  c_op_load  = 7'b0000011;
    localparam logic [6:0]  c_op_jalr  = 7'b1100111;
    localparam logic [6:0]  c_op_store = 7'b0100011;
    localparam logic [6:0]  c_op_br    = 7'b1100011;
    localparam logic [6:0]  c_op_lui   = 7'b0110111;
    localparam logic [6:0]  c_op_auipc = 7'b0010111;
    localparam logic [6:0]  c_op_jal   = 7'b1101111;
    localparam logic [6:0]  c_op_reg   = 7'b0110011;

    logic        r_valid;
    logic [31:0] r_instr;
    logic        r_err;
    logic [15:0] r_enc_cnt;
    logic [7:0]  r_err_cnt;

    logic [31:0] w_field_word;
    logic        w_range_ok;
    logic        w_legal_op;
    logic [31:0] w_word;
    logic        w_err;
    logic        w_accept;

    // Field packing and range test per format. Range tests ask whether the
    // immediate survives the mapping without loss: the dropped high bits must
    // be sign copies, and the dropped low bits must be zero.
    always_comb begin
        w_field_word = c_nop;
        w_range_ok   = 1'b1;
        w_legal_op   = 1'b1;
        case (in_opcode)
            c_op_imm, c_op_load, c_op_jalr: begin
                w_field_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                w_range_ok   = (&in_imm[31:11]) | ~(|in_imm[31:11]);
            end
            c_op_store: begin
                w_field_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:0], in_opcode};
                w_range_ok   = (&in_imm[31:11]) | ~(|in_imm[31:11]);
            end
            c_op_br: begin
                w_field_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:1], in_imm[11], in_opcode};
                w_range_ok   = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
            end
            c_op_lui, c_op_auipc: begin
                w_field_word = {in_imm[31:12], in_rd, in_opcode};
                w_range_ok   = ~(|in_imm[11:0]);
            end
            c_op_jal: begin
                w_field_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                in_rd, in_opcode};
                w_range_ok   = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
            end
            c_op_reg: begin
                w_field_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            default: begin
                w_legal_op   = 1'b0;
            end
        endcase
    end

    // An illegal opcode is always an error. A range violation is an error
    // only when checking is enabled; otherwise the truncated word goes out.
    always_comb begin
        w_word = w_field_word;
        w_err  = 1'b0;
        if (!w_legal_op || (c_check && !w_range_ok)) begin
            w_word = c_nop;
            w_err  = 1'b1;
        end
    end

    // The output register may be refilled in the same cycle it is drained,
    // so back-to-back requests see no bubble.
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= 32'h0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_instr <= w_word;
            r_err   <= w_err;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Clear takes priority over a same-cycle increment. enc_count wraps
    // naturally; err_count holds at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enc_cnt <= 16'h0;
            r_err_cnt <= 8'h0;
        end else if (clr_cnt) begin
            r_enc_cnt <= 16'h0;
            r_err_cnt <= 8'h0;
        end else if (w_accept) begin
            r_enc_cnt <= r_enc_cnt + 16'd1;
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_instr = r_instr;
    assign out_err   = r_err;
    assign enc_count = r_enc_cnt;
    assign err_count = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Self-checking bench for instr_encoder. Two DUT copies share all
//            inputs: one has IMM_CHECK=1 and the other IMM_CHECK=0. Each
//            accepted request pushes its expected words onto a queue. Each
//            output handshake pops one entry and compares both copies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam logic [6:0] c_op_imm   = 7'b0010011;
    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;
    localparam logic [6:0] c_op_br    = 7'b1100011;
    localparam logic [6:0] c_op_lui   = 7'b0110111;
    localparam logic [6:0] c_op_auipc = 7'b0010111;
    localparam logic [6:0] c_op_jal   = 7'b1101111;
    localparam logic [6:0] c_op_reg   = 7'b0110011;
    localparam logic [6:0] c_op_bad   = 7'b1111111;
    localparam int         c_nvec     = 15;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] e_instr;   // IMM_CHECK=1 copy
        logic        e_err;
        logic [31:0] e0_instr;  // IMM_CHECK=0 copy
        logic        e0_err;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready, in_ready0;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid, out_valid0;
    logic        out_ready;
    logic [31:0] out_instr, out_instr0;
    logic        out_err, out_err0;
    logic        clr_cnt;
    logic [15:0] enc_count, enc_count0;
    logic [7:0]  err_count, err_count0;

    int   checks;
    int   failures;
    vec_t vecs [c_nvec];
    vec_t cur;
    vec_t sb [$];

    instr_encoder #(.IMM_CHECK(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .clr_cnt(clr_cnt), .enc_count(enc_count),
        .err_count(err_count)
    );

    instr_encoder #(.IMM_CHECK(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid0), .out_ready(out_ready), .out_instr(out_instr0),
        .out_err(out_err0), .clr_cnt(clr_cnt), .enc_count(enc_count0),
        .err_count(err_count0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic send(input vec_t v);
        in_valid  = 1'b1;
        in_opcode = v.op;
        in_rd     = v.rd;
        in_funct3 = v.f3;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct7 = v.f7;
        in_imm    = v.imm;
        cur       = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor. It samples on the falling edge, which sits halfway
    // between the driver updates and the DUT's active edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_word", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                check("sb_instr", out_instr, e.e_instr);
                check("sb_err", {31'd0, out_err}, {31'd0, e.e_err});
                check("sb_instr0", out_instr0, e.e0_instr);
                check("sb_err0", {31'd0, out_err0}, {31'd0, e.e0_err});
            end
        end
        if (rst_n && in_valid && in_ready) begin
            sb.push_back(cur);
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t addi_v, lui_v, add_v, bad_v, lw_v;
        int   n_err, n_err0;

        checks   = 0;
        failures = 0;
        //            op          rd  f3 rs1 rs2 f7          imm            exp1          e  exp0          e0
        vecs[0]  = '{c_op_imm,   1,  0, 2,  0,  0,          32'hFFFFFFFF, 32'hFFF10093, 0, 32'hFFF10093, 0};
        vecs[1]  = '{c_op_store, 0,  2, 2,  5,  0,          32'h00000008, 32'h00512423, 0, 32'h00512423, 0};
        vecs[2]  = '{c_op_br,    0,  0, 1,  2,  0,          32'hFFFFFFFC, 32'hFE208EE3, 0, 32'hFE208EE3, 0};
        vecs[3]  = '{c_op_lui,   5,  0, 0,  0,  0,          32'h12345000, 32'h123452B7, 0, 32'h123452B7, 0};
        vecs[4]  = '{c_op_imm,   0,  0, 0,  0,  0,          32'h00000800, 32'h00000013, 1, 32'h80000013, 0};
        vecs[5]  = '{c_op_reg,   3,  0, 1,  2,  0,          32'hDEADBEEF, 32'h002081B3, 0, 32'h002081B3, 0};
        vecs[6]  = '{c_op_reg,   3,  0, 1,  2,  7'b0100000, 32'h00000000, 32'h402081B3, 0, 32'h402081B3, 0};
        vecs[7]  = '{c_op_bad,   1,  0, 2,  3,  0,          32'h00000000, 32'h00000013, 1, 32'h00000013, 1};
        vecs[8]  = '{c_op_jal,   1,  0, 0,  0,  0,          32'h00000008, 32'h008000EF, 0, 32'h008000EF, 0};
        vecs[9]  = '{c_op_jal,   1,  0, 0,  0,  0,          32'h00000001, 32'h00000013, 1, 32'h000000EF, 0};
        vecs[10] = '{c_op_br,    0,  0, 0,  0,  0,          32'h00000002, 32'h00000163, 0, 32'h00000163, 0};
        vecs[11] = '{c_op_auipc, 0,  0, 0,  0,  0,          32'h00001001, 32'h00000013, 1, 32'h00001017, 0};
        vecs[12] = '{c_op_load,  5,  2, 2,  0,  0,          32'h00000004, 32'h00412283, 0, 32'h00412283, 0};
        vecs[13] = '{c_op_store, 0,  2, 2,  5,  0,          32'h00000800, 32'h00000013, 1, 32'h80512023, 0};
        vecs[14] = '{c_op_imm,   1,  0, 2,  0,  0,          32'hFFFFF800, 32'h80010093, 0, 32'h80010093, 0};
        addi_v = vecs[0];
        lui_v  = vecs[3];
        add_v  = vecs[5];
        bad_v  = vecs[7];
        lw_v   = vecs[12];

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        in_opcode = '0; in_rd = '0; in_funct3 = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct7 = '0; in_imm = '0; cur = addi_v;

        // Reset state
        repeat (2) tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_enc_count", {16'd0, enc_count}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // First ADDI: one-cycle latency and enc_count=1
        send(addi_v);
        tick();
        in_valid = 1'b0;
        check("addi_valid", {31'd0, out_valid}, 32'd1);
        check("addi_instr", out_instr, 32'hFFF10093);
        check("addi_enc_count", {16'd0, enc_count}, 32'd1);
        tick();
        check("drain_valid_low", {31'd0, out_valid}, 32'd0);

        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_enc_count", {16'd0, enc_count}, 32'd0);

        // Table vectors, back to back
        n_err = 0;
        n_err0 = 0;
        for (int i = 0; i < c_nvec; i++) begin
            send(vecs[i]);
            if (vecs[i].e_err)  n_err++;
            if (vecs[i].e0_err) n_err0++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("tbl_enc_count", {16'd0, enc_count}, c_nvec);
        check("tbl_err_count", {24'd0, err_count}, n_err);
        check("tbl_err_count0", {24'd0, err_count0}, n_err0);
        check("tbl_sb_empty", sb.size(), 32'd0);

        // Backpressure: LUI is held for 3 stall cycles while ADD waits
        out_ready = 1'b0;
        send(lui_v);
        tick();
        send(add_v);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_instr_held", out_instr, 32'h123452B7);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp_no_bubble_valid", {31'd0, out_valid}, 32'd1);
        check("bp_next_instr", out_instr, 32'h002081B3);
        tick();
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Clear concurrent with an accept
        send(addi_v);
        clr_cnt = 1'b1;
        tick();
        in_valid = 1'b0;
        clr_cnt = 1'b0;
        check("clracc_enc_count", {16'd0, enc_count}, 32'd0);
        check("clracc_err_count", {24'd0, err_count}, 32'd0);
        check("clracc_valid", {31'd0, out_valid}, 32'd1);
        check("clracc_instr", out_instr, 32'hFFF10093);
        tick();

        // Reset in the middle of a stall
        out_ready = 1'b0;
        send(bad_v);
        tick();
        in_valid = 1'b0;
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_err_count", {24'd0, err_count}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_instr", out_instr, 32'd0);
        check("rst_mid_err", {31'd0, out_err}, 32'd0);
        check("rst_mid_enc_count", {16'd0, enc_count}, 32'd0);
        check("rst_mid_err_count", {24'd0, err_count}, 32'd0);
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        send(lw_v);
        tick();
        in_valid = 1'b0;
        check("post_rst_enc_count", {16'd0, enc_count}, 32'd1);
        check("post_rst_instr", out_instr, 32'h00412283);
        tick();

        // Counters: 300 errors saturate err_count; 65536 accepts wrap enc_count
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            send((i < 300) ? bad_v : vecs[i % 4]);
            tick();
            if (i == 299) begin
                check("err_sat_at_300", {24'd0, err_count}, 32'hFF);
                check("enc_at_300", {16'd0, enc_count}, 32'd300);
            end
        end
        check("enc_count_ffff", {16'd0, enc_count}, 32'hFFFF);
        send(addi_v);
        tick();
        in_valid = 1'b0;
        check("enc_count_wrap", {16'd0, enc_count}, 32'd0);
        check("err_count_sat", {24'd0, err_count}, 32'hFF);
        tick();
        tick();
        check("final_sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
